// File: rtl/uart_cmd_pkg.sv
// Byte classes, command codes and FSM state types shared by the UART command register bank.
// Combinational decode only. No latency and no backpressure live here.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_M  = 8'h6D;
    localparam logic [7:0] CMD_W  = 8'h77;
    localparam logic [7:0] CMD_I  = 8'h69;
    localparam logic [7:0] CMD_R  = 8'h72;
    localparam logic [7:0] CMD_N  = 8'h6E;
    localparam logic [7:0] CMD_C  = 8'h63;
    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] NIB_LO = 8'h30;
    localparam logic [7:0] NIB_HI = 8'h3F;

    typedef enum logic [1:0] {ST_IDLE, ST_CONSUME, ST_EXEC, ST_RESP} state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_PULSE, TX_GAP} tx_state_t;
    typedef enum logic [2:0] {OP_NIB, OP_ADDR, OP_CLR, OP_WR, OP_RD, OP_DROP, OP_ERR} op_t;

    typedef struct packed {
        op_t  op;
        logic incr;
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [7:0] b);
        cmd_t c;
        c.op   = OP_ERR;
        c.incr = 1'b0;
        if (b >= NIB_LO && b <= NIB_HI) begin
            c.op = OP_NIB;
        end else begin
            case (b)
                CMD_M:          c.op = OP_ADDR;
                CMD_C:          c.op = OP_CLR;
                CMD_W:          c.op = OP_WR;
                CMD_I:          begin c.op = OP_WR; c.incr = 1'b1; end
                CMD_R:          c.op = OP_RD;
                CMD_N:          begin c.op = OP_RD; c.incr = 1'b1; end
                CHR_CR, CHR_LF: c.op = OP_DROP;
                default:        c.op = OP_ERR;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/regbank_tx_seq.sv
// Serialises a DATA_W read value into raw bytes, most significant byte first.
// Latency: one cycle from start to the first wait. Backpressure: each byte waits in TX_WAIT for i_tx_ready.
module regbank_tx_seq
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_value,
    input  logic [CNT_W-1:0]  i_nbytes,
    input  logic              i_tx_ready,
    output logic              o_tx_write,
    output logic [7:0]        o_tx_data,
    output logic              o_done
);

    tx_state_t         r_state;
    tx_state_t         w_state_nx;
    logic [DATA_W-1:0] r_val;
    logic [CNT_W-1:0]  r_left;
    logic [7:0]        r_tx_data;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            TX_IDLE:  if (i_start) w_state_nx = TX_WAIT;
            TX_WAIT:  if (i_tx_ready) w_state_nx = TX_PULSE;
            TX_PULSE: w_state_nx = TX_GAP;
            // The gap cycle lets the transmitter drop tx_ready before it is looked at again.
            TX_GAP:   w_state_nx = (r_left == '0) ? TX_IDLE : TX_WAIT;
            default:  w_state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= TX_IDLE;
            r_val     <= '0;
            r_left    <= '0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == TX_IDLE && i_start) begin
                r_val  <= i_value;
                r_left <= i_nbytes;
            end else if (r_state == TX_WAIT && i_tx_ready) begin
                r_tx_data <= r_val[DATA_W-1 -: 8];
                r_val     <= r_val << 8;
                r_left    <= r_left - CNT_W'(1);
            end
        end
    end

    assign o_tx_write = (r_state == TX_PULSE);
    assign o_tx_data  = r_tx_data;
    assign o_done     = (r_state == TX_GAP) && (r_left == '0);

endmodule

// File: rtl/uart_cmd_regbank.sv
// UART byte-command parser driving a bank of output registers and reading back input/output registers.
// Latency: rx_ready->rx_read 1 cycle, write 2 cycles. Backpressure: rx held off while a response drains on tx_ready.
module uart_cmd_regbank
    import uart_cmd_pkg::*;
#(
    parameter int                    DATA_W    = 8,
    parameter int                    ADDR_W    = 8,
    parameter int                    N_OUT     = 20,
    parameter int                    N_IN      = 9,
    parameter logic [N_OUT*DATA_W-1:0] OUT_RESET = '0
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_ready,
    output logic                    o_rx_read,
    output logic [7:0]              o_tx_data,
    input  logic                    i_tx_ready,
    output logic                    o_tx_write,
    output logic [N_OUT*DATA_W-1:0] o_out_ports,
    output logic [N_OUT-1:0]        o_wr_strobe,
    input  logic [N_IN*DATA_W-1:0]  i_in_ports,
    output logic [7:0]              o_err_count
);

    localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(NB + 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic              r_hold;
    logic [7:0]        r_cmd;
    logic [SH_W-1:0]   r_shift;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_out [N_OUT];
    logic [7:0]        r_err;

    cmd_t              w_cmd;
    logic              w_exec;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_err;
    logic              w_start;
    logic              w_tx_done;
    logic [ADDR_W-2:0] w_idx;
    logic [DATA_W-1:0] w_rd_val;
    logic [N_OUT-1:0]  w_strobe;

    assign w_cmd   = decode_cmd(r_cmd);
    assign w_exec  = (r_state == ST_EXEC);
    assign w_idx   = r_addr[ADDR_W-2:0];
    assign w_wr_ok = (r_addr < ADDR_W'(N_OUT));

    // Top address bit selects output readback; unmapped slots read as all-ones.
    always_comb begin
        w_rd_val = '1;
        w_rd_ok  = 1'b0;
        if (!r_addr[ADDR_W-1]) begin
            for (int k = 0; k < N_IN; k++) begin
                if (w_idx == (ADDR_W-1)'(k)) begin
                    w_rd_val = i_in_ports[k*DATA_W +: DATA_W];
                    w_rd_ok  = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (w_idx == (ADDR_W-1)'(k)) begin
                    w_rd_val = r_out[k];
                    w_rd_ok  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_strobe = '0;
        if (w_exec && w_cmd.op == OP_WR) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (r_addr == ADDR_W'(k)) w_strobe[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_err = 1'b0;
        if (w_exec) begin
            case (w_cmd.op)
                OP_ERR:  w_err = 1'b1;
                OP_WR:   w_err = !w_wr_ok;
                OP_RD:   w_err = !w_rd_ok;
                default: w_err = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_nx = r_state;
        o_rx_read  = 1'b0;
        w_start    = 1'b0;
        case (r_state)
            // r_hold masks the stale rx_ready that has not yet dropped after the previous rx_read.
            ST_IDLE:    if (i_rx_ready && !r_hold) w_state_nx = ST_CONSUME;
            ST_CONSUME: begin
                o_rx_read  = 1'b1;
                w_state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_cmd.op == OP_RD) begin
                    w_start    = 1'b1;
                    w_state_nx = ST_RESP;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RESP:    if (w_tx_done) w_state_nx = ST_IDLE;
            default:    w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_hold  <= 1'b0;
            r_cmd   <= '0;
            r_shift <= '0;
            r_addr  <= '0;
            r_err   <= '0;
            for (int k = 0; k < N_OUT; k++) r_out[k] <= OUT_RESET[k*DATA_W +: DATA_W];
        end else begin
            r_state <= w_state_nx;
            r_hold  <= w_exec;
            if (r_state == ST_CONSUME) r_cmd <= i_rx_data;
            if (w_exec) begin
                case (w_cmd.op)
                    OP_NIB:  r_shift <= {r_shift[SH_W-5:0], r_cmd[3:0]};
                    OP_ADDR: r_addr  <= r_shift[ADDR_W-1:0];
                    OP_CLR:  r_shift <= '0;
                    default: ;
                endcase
                if (w_cmd.incr) r_addr <= r_addr + ADDR_W'(1);
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (w_strobe[k]) r_out[k] <= r_shift[DATA_W-1:0];
            end
            if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
        end
    end

    regbank_tx_seq #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_tx_seq (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_start),
        .i_value    (w_rd_val),
        .i_nbytes   (CNT_W'(NB)),
        .i_tx_ready (i_tx_ready),
        .o_tx_write (o_tx_write),
        .o_tx_data  (o_tx_data),
        .o_done     (w_tx_done)
    );

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign o_out_ports[g*DATA_W +: DATA_W] = r_out[g];
    end

    assign o_wr_strobe = w_strobe;
    assign o_err_count = r_err;

endmodule

// File: tb/tb_uart_cmd_regbank.sv
// Bench for uart_cmd_regbank: an 8-bit and a 16-bit instance driven by a uart_rx/uart_tx model,
// tx bytes and write strobes checked by a monitor against queued expectations.
module tb_uart_cmd_regbank;
    timeunit 1ns;
    timeprecision 1ps;

    function automatic logic [159:0] mk_rst0();
        logic [159:0] r;
        for (int k = 0; k < 20; k++) r[k*8 +: 8] = 8'h40 + 8'(k);
        return r;
    endfunction

    function automatic logic [319:0] mk_rst1();
        logic [319:0] r;
        for (int k = 0; k < 20; k++) r[k*16 +: 16] = 16'hB000 + 16'(k);
        return r;
    endfunction

    localparam logic [159:0] RST0 = mk_rst0();
    localparam logic [319:0] RST1 = mk_rst1();

    typedef struct { int u; logic [7:0] b; } txe_t;
    typedef struct { int u; int idx; } stbe_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data [2];
    logic         rx_ready [2];
    logic         rx_read [2];
    logic [7:0]   tx_data [2];
    logic         tx_ready [2];
    logic         tx_write [2];
    logic         tx_en [2];
    logic [19:0]  stb [2];
    logic [159:0] out0;
    logic [319:0] out1;
    logic [71:0]  in0;
    logic [143:0] in1;
    logic [7:0]   err0, err1;

    int           n_checks = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           rd_cyc [2];
    int           tx_cnt [2];
    int           busy [2];
    logic [15:0]  mdl [2][20];
    txe_t         q_tx[$];
    stbe_t        q_stb[$];

    uart_cmd_regbank #(.DATA_W(8), .ADDR_W(8), .N_OUT(20), .N_IN(9), .OUT_RESET(RST0)) u_dut8 (
        .i_clk(clk), .i_reset(reset),
        .i_rx_data(rx_data[0]), .i_rx_ready(rx_ready[0]), .o_rx_read(rx_read[0]),
        .o_tx_data(tx_data[0]), .i_tx_ready(tx_ready[0]), .o_tx_write(tx_write[0]),
        .o_out_ports(out0), .o_wr_strobe(stb[0]), .i_in_ports(in0), .o_err_count(err0)
    );

    uart_cmd_regbank #(.DATA_W(16), .ADDR_W(8), .N_OUT(20), .N_IN(9), .OUT_RESET(RST1)) u_dut16 (
        .i_clk(clk), .i_reset(reset),
        .i_rx_data(rx_data[1]), .i_rx_ready(rx_ready[1]), .o_rx_read(rx_read[1]),
        .o_tx_data(tx_data[1]), .i_tx_ready(tx_ready[1]), .o_tx_write(tx_write[1]),
        .o_out_ports(out1), .o_wr_strobe(stb[1]), .i_in_ports(in1), .o_err_count(err1)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for three cycles after each tx_write.
    assign tx_ready[0] = tx_en[0] && (busy[0] == 0);
    assign tx_ready[1] = tx_en[1] && (busy[1] == 0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        txe_t  te;
        stbe_t se;
        for (int u = 0; u < 2; u++) begin
            if (tx_write[u]) begin
                busy[u]   <= 3;
                tx_cnt[u] <= tx_cnt[u] + 1;
                if (q_tx.size() == 0) begin
                    chk($sformatf("tx%0d unexpected byte", u), 32'(tx_data[u]) | 32'h100, 32'h0);
                end else begin
                    te = q_tx.pop_front();
                    chk($sformatf("tx%0d byte", u), (u << 8) | 32'(tx_data[u]), (te.u << 8) | 32'(te.b));
                end
            end else if (busy[u] != 0) begin
                busy[u] <= busy[u] - 1;
            end
            if (stb[u] != '0) begin
                if (q_stb.size() == 0) begin
                    chk($sformatf("wr_strobe%0d unexpected", u), 32'(stb[u]), 32'h0);
                end else begin
                    se = q_stb.pop_front();
                    chk($sformatf("wr_strobe%0d", u), (u << 24) | 32'(stb[u]), (se.u << 24) | (32'd1 << se.idx));
                    chk($sformatf("wr_strobe%0d latency", u), 32'(cyc - rd_cyc[u]), 32'd1);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int u, input logic [7:0] b);
        int  n = 0;
        bit  got = 1'b0;
        rx_data[u]  = b;
        rx_ready[u] = 1'b1;
        while (!got && n < 500) begin
            @(negedge clk);
            n++;
            if (rx_read[u]) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL rx_read%0d timeout: byte %h not consumed, expected rx_read", u, b);
        end
        rd_cyc[u] = cyc;
        @(posedge clk);
        #1 rx_ready[u] = 1'b0;
    endtask

    task automatic send_str(input int u, input string s);
        for (int i = 0; i < s.len(); i++) send(u, s[i]);
    endtask

    task automatic send_hex(input int u, input logic [31:0] v, input int nd);
        for (int i = nd - 1; i >= 0; i--) send(u, 8'h30 | {4'h0, v[i*4 +: 4]});
    endtask

    task automatic exp_tx(input int u, input logic [7:0] b);
        txe_t e;
        e.u = u;
        e.b = b;
        q_tx.push_back(e);
    endtask

    task automatic exp_wr(input int u, input int idx, input logic [15:0] v);
        stbe_t e;
        e.u   = u;
        e.idx = idx;
        q_stb.push_back(e);
        mdl[u][idx] = v;
    endtask

    task automatic drain();
        int n = 0;
        while (q_tx.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (q_tx.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain timeout: %0d bytes outstanding, expected 0", q_tx.size());
        end
        step(6);
    endtask

    task automatic mdl_reset();
        for (int k = 0; k < 20; k++) begin
            mdl[0][k] = {8'h00, RST0[k*8 +: 8]};
            mdl[1][k] = RST1[k*16 +: 16];
        end
    endtask

    task automatic chk_img(input int u, input string nm);
        logic [15:0] a;
        int          bad = -1;
        logic [15:0] ba = '0;
        logic [15:0] be = '0;
        for (int k = 0; k < 20; k++) begin
            a = (u == 0) ? {8'h00, out0[k*8 +: 8]} : out1[k*16 +: 16];
            if (a !== mdl[u][k] && bad < 0) begin
                bad = k;
                ba  = a;
                be  = mdl[u][k];
            end
        end
        n_checks++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s reg %0d: got %h expected %h", nm, bad, ba, be);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            rx_data[u] = 8'h00; rx_ready[u] = 1'b0; tx_en[u] = 1'b1;
            rd_cyc[u] = 0; tx_cnt[u] = 0; busy[u] = 0;
        end
        for (int k = 0; k < 9; k++) begin
            in0[k*8 +: 8]   = 8'h80 + 8'(k);
            in1[k*16 +: 16] = 16'hA100 + 16'(k);
        end
        in0[2*8 +: 8] = 8'hC5;
        mdl_reset();
        step(3);
        reset = 1'b0;
        step(1);

        chk("reset err0", err0, 0);
        chk("reset err1", err1, 0);
        chk_img(0, "reset image u0");
        chk_img(1, "reset image u1");
        chk("reset tx_write/rx_read", {tx_write[0], tx_write[1], rx_read[0], rx_read[1]}, 0);
        chk("reset tx_data", {tx_data[0], tx_data[1]}, 0);
        chk("reset wr_strobe", {stb[0], stb[1]}, 0);

        // 8-bit write, then CR/LF, then 'c' clears the shift register before a write.
        send_hex(0, 32'h05, 2); send(0, "m"); send_hex(0, 32'h3A, 2);
        exp_wr(0, 5, 16'h003A); send(0, "w"); step(3);
        chk_img(0, "write 05m3Aw");
        send(0, 8'h0D); send(0, 8'h0A); step(4);
        chk("err after CR/LF", err0, 0);
        send_hex(0, 32'h07, 2); send(0, "m"); send(0, "c");
        exp_wr(0, 7, 16'h0000); send(0, "w"); step(3);
        chk_img(0, "write after clear");

        // Read of in_ports[2] held back by a busy transmitter.
        tx_en[0] = 1'b0;
        send_hex(0, 32'h02, 2); send(0, "m");
        exp_tx(0, 8'hC5); send(0, "r");
        n0 = tx_cnt[0];
        step(50);
        chk("tx_write held by tx_ready", tx_cnt[0], n0);
        tx_en[0] = 1'b1;
        drain();

        // Out-of-range write and read, readback, address wrap.
        send_hex(0, 32'h40, 2); send(0, "m"); send_hex(0, 32'h99, 2); send(0, "w"); step(3);
        chk_img(0, "write addr 0x40 ignored");
        chk("err after bad write", err0, 1);
        send_hex(0, 32'h7F, 2); send(0, "m"); exp_tx(0, 8'hFF); send(0, "r"); drain();
        chk("err after bad read", err0, 2);
        send_hex(0, 32'h85, 2); send(0, "m"); exp_tx(0, 8'h3A); send(0, "r"); drain();
        send_hex(0, 32'hFF, 2); send(0, "m"); exp_tx(0, 8'hFF); send(0, "n");
        exp_tx(0, 8'h80); send(0, "r"); drain();
        chk("err after wrap read", err0, 3);

        // Saturation of the error counter.
        repeat (252) send(0, "Z");
        step(4);
        chk("err reaches 0xFF", err0, 8'hFF);
        repeat (48) send(0, "Z");
        send(0, 8'h0D); send(0, 8'h0A); step(4);
        chk("err saturated", err0, 8'hFF);

        // 16-bit auto-increment writes and readback reads.
        send_str(1, "00m"); send_hex(1, 32'h1234, 4);
        exp_wr(1, 0, 16'h1234); send(1, "i");
        send_hex(1, 32'h5678, 4);
        exp_wr(1, 1, 16'h5678); send(1, "i"); step(3);
        chk_img(1, "16-bit writes");
        send_str(1, "00m"); send_str(1, "80m");
        exp_tx(1, 8'h12); exp_tx(1, 8'h34); send(1, "n");
        exp_tx(1, 8'h56); exp_tx(1, 8'h78); send(1, "n");
        exp_tx(1, 8'hB0); exp_tx(1, 8'h02); send(1, "r"); drain();
        chk("err u1", err1, 0);

        // Reset between the two bytes of a 16-bit response.
        send_str(1, "80m");
        exp_tx(1, 8'h12); exp_tx(1, 8'h34);
        n0 = tx_cnt[1];
        send(1, "r");
        for (int i = 0; i < 200 && tx_cnt[1] == n0; i++) @(posedge clk);
        chk("first byte before reset", tx_cnt[1], n0 + 1);
        #1 reset = 1'b1;
        @(posedge clk);
        #2;
        mdl_reset();
        chk("reset tx_write u1", tx_write[1], 0);
        chk("reset tx_data u1", tx_data[1], 0);
        chk("reset rx_read/strobe u1", {rx_read[1], stb[1]}, 0);
        chk("reset err both", {err0, err1}, 0);
        chk_img(0, "reset mid-response u0");
        chk_img(1, "reset mid-response u1");
        reset = 1'b0;
        chk("aborted bytes pending", q_tx.size(), 1);
        q_tx.delete();
        step(20);
        chk("no tx_write after reset", tx_cnt[1], n0 + 1);
        send_str(1, "01m");
        exp_tx(1, 8'hA1); exp_tx(1, 8'h01); send(1, "r"); drain();
        chk("strobe queue empty", q_stb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
